// File: rtl/timer_pkg.sv
// Shared definitions for the microwave keypad front end.
// Holds the key codes, the BCD digit width and the sequencing state type.
package timer_pkg;

  localparam int unsigned DigitW = 4;

  localparam logic [3:0] KEY_CLEAR = 4'hA;
  localparam logic [3:0] KEY_START = 4'hB;

  typedef logic [DigitW-1:0] bcd_t;

  typedef enum logic [2:0] {
    StIdle,
    StEntry,
    StLoad,
    StRun,
    StPause
  } state_e;

  function automatic logic is_digit(logic [3:0] code);
    return code <= 4'd9;
  endfunction

endpackage

// File: rtl/timer_key_sync.sv
// Key strobe synchroniser and rising-edge detector.
// Gives one key_press pulse per press of the asynchronous key strobe.
// Ports:
//   clk_i        system clock, rising edge
//   clr_i        asynchronous active-high reset
//   key_valid_i  asynchronous keypad strobe (level)
//   key_press_o  one-cycle pulse on each synchronised rising edge
module timer_key_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic clr_i,
  input  logic key_valid_i,
  output logic key_press_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  always_ff @(posedge clk_i or posedge clr_i) begin
    if (clr_i) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], key_valid_i};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign key_press_o = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/timer_key_entry.sv
// Microwave keypad front end for the mm:ss down-counter chain.
// Shifts BCD digits in right to left, presents them to the counter data inputs, and
// sequences load/run/pause of the chain, ending the cook cycle on timer_zero.
// Optional feature: define TIMER_QUICK_START_EN so that start in idle loads QUICK_SEC
// seconds and begins cooking; QUICK_SEC (0..59) exists only in that build.
// Ports:
//   clk_i, clr_i       clock, asynchronous active-high reset
//   key_valid_i        asynchronous key strobe; key_code_i stable while it is high
//   key_code_i         0-9 digit, A clear, B start, C-F ignored
//   timer_zero_i       counter chain reached 00:00
//   min_tens_o .. sec_ones_o  BCD digits to the counters
//   loadn_o            active-low one-cycle load strobe
//   run_o              counter enable (high while loading and running)
//   key_err_o          one-cycle pulse when a key is rejected
module timer_key_entry
  import timer_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2
`ifdef TIMER_QUICK_START_EN
  ,
  parameter int unsigned QUICK_SEC   = 30
`endif
) (
  input  logic       clk_i,
  input  logic       clr_i,
  input  logic       key_valid_i,
  input  logic [3:0] key_code_i,
  input  logic       timer_zero_i,
  output logic [3:0] min_tens_o,
  output logic [3:0] min_ones_o,
  output logic [3:0] sec_tens_o,
  output logic [3:0] sec_ones_o,
  output logic       loadn_o,
  output logic       run_o,
  output logic       key_err_o
);

`ifdef TIMER_QUICK_START_EN
  localparam bcd_t QuickTens = bcd_t'(QUICK_SEC / 10);
  localparam bcd_t QuickOnes = bcd_t'(QUICK_SEC % 10);
`endif

  logic   key_press;
  state_e state_q, state_d;
  bcd_t   mt_q, mt_d, mo_q, mo_d, st_q, st_d, so_q, so_d;
  logic [2:0] cnt_q, cnt_d;
  logic   loadn_q, loadn_d, run_q, run_d, err_q, err_d;
  logic   is_dig, is_clr, is_start;

  timer_key_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk_i      (clk_i),
    .clr_i      (clr_i),
    .key_valid_i(key_valid_i),
    .key_press_o(key_press)
  );

  assign is_dig   = key_press & is_digit(key_code_i);
  assign is_clr   = key_press & (key_code_i == KEY_CLEAR);
  assign is_start = key_press & (key_code_i == KEY_START);

  always_comb begin
    state_d = state_q;
    mt_d    = mt_q;
    mo_d    = mo_q;
    st_d    = st_q;
    so_d    = so_q;
    cnt_d   = cnt_q;
    err_d   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (is_dig) begin
          so_d    = key_code_i;
          cnt_d   = 3'd1;
          state_d = StEntry;
        end else if (is_start) begin
`ifdef TIMER_QUICK_START_EN
          st_d    = QuickTens;
          so_d    = QuickOnes;
          cnt_d   = 3'd2;
          state_d = StLoad;
`else
          err_d   = 1'b1;
`endif
        end
      end
      StEntry: begin
        if (is_dig) begin
          // A shifted sec_ones above 5 would make sec_tens invalid for the counter.
          if (cnt_q == 3'd4 || so_q > 4'd5) begin
            err_d = 1'b1;
          end else begin
            mt_d  = mo_q;
            mo_d  = st_q;
            st_d  = so_q;
            so_d  = key_code_i;
            cnt_d = cnt_q + 3'd1;
          end
        end else if (is_clr) begin
          {mt_d, mo_d, st_d, so_d} = '0;
          cnt_d   = 3'd0;
          state_d = StIdle;
        end else if (is_start) begin
          if ({mt_q, mo_q, st_q, so_q} == '0) err_d = 1'b1;
          else state_d = StLoad;
        end
      end
      StLoad: state_d = StRun;
      StRun: begin
        // End of cook beats any key arriving in the same cycle.
        if (timer_zero_i) begin
          {mt_d, mo_d, st_d, so_d} = '0;
          cnt_d   = 3'd0;
          state_d = StIdle;
        end else if (is_dig || is_start) begin
          err_d = 1'b1;
        end else if (is_clr) begin
          state_d = StPause;
        end
      end
      StPause: begin
        if (is_start) begin
          state_d = StRun;
        end else if (is_clr) begin
          {mt_d, mo_d, st_d, so_d} = '0;
          cnt_d   = 3'd0;
          state_d = StIdle;
        end else if (is_dig) begin
          err_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    run_d   = (state_d == StLoad) || (state_d == StRun);
    loadn_d = (state_d != StLoad);
  end

  always_ff @(posedge clk_i or posedge clr_i) begin
    if (clr_i) begin
      state_q <= StIdle;
      mt_q    <= '0;
      mo_q    <= '0;
      st_q    <= '0;
      so_q    <= '0;
      cnt_q   <= '0;
      loadn_q <= 1'b1;
      run_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mt_q    <= mt_d;
      mo_q    <= mo_d;
      st_q    <= st_d;
      so_q    <= so_d;
      cnt_q   <= cnt_d;
      loadn_q <= loadn_d;
      run_q   <= run_d;
      err_q   <= err_d;
    end
  end

  assign min_tens_o = mt_q;
  assign min_ones_o = mo_q;
  assign sec_tens_o = st_q;
  assign sec_ones_o = so_q;
  assign loadn_o    = loadn_q;
  assign run_o      = run_q;
  assign key_err_o  = err_q;

endmodule

// File: tb/tb_timer_key_entry.sv
// Self-checking bench for timer_key_entry: directed vector table, hand sequences for
// reset/timer_zero corner cases, and random key traffic against a queue-based model.
module tb_timer_key_entry;

  localparam int QuickSec = 30;

  logic       clk_i = 1'b0;
  logic       clr_i;
  logic       key_valid_i;
  logic [3:0] key_code_i;
  logic       timer_zero_i;
  logic [3:0] min_tens_o, min_ones_o, sec_tens_o, sec_ones_o;
  logic       loadn_o, run_o, key_err_o;

  timer_key_entry u_dut (
    .clk_i       (clk_i),
    .clr_i       (clr_i),
    .key_valid_i (key_valid_i),
    .key_code_i  (key_code_i),
    .timer_zero_i(timer_zero_i),
    .min_tens_o  (min_tens_o),
    .min_ones_o  (min_ones_o),
    .sec_tens_o  (sec_tens_o),
    .sec_ones_o  (sec_ones_o),
    .loadn_o     (loadn_o),
    .run_o       (run_o),
    .key_err_o   (key_err_o)
  );

  always #5 clk_i = ~clk_i;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   err_cnt  = 0;
  int   load_cnt = 0;
  logic loadn_prev = 1'b1;

  // Pulse counters; every load strobe must be one cycle long with run high.
  always @(negedge clk_i) begin
    if (key_err_o) err_cnt++;
    if (!loadn_o) begin
      load_cnt++;
      n_checks++;
      if (!run_o || !loadn_prev) begin
        n_fail++;
        $display("FAIL load_strobe: run=%0b prev_loadn=%0b, required run=1 prev_loadn=1",
                 run_o, loadn_prev);
      end
    end
    loadn_prev = loadn_o;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  function automatic int digits();
    return {16'h0, min_tens_o, min_ones_o, sec_tens_o, sec_ones_o};
  endfunction

  task automatic press(input logic [3:0] code, input int hold);
    @(negedge clk_i);
    key_code_i  = code;
    key_valid_i = 1'b1;
    repeat (hold) @(negedge clk_i);
    key_valid_i = 1'b0;
    repeat (5) @(negedge clk_i);
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    clr_i        = 1'b1;
    key_valid_i  = 1'b0;
    timer_zero_i = 1'b0;
    key_code_i   = 4'h0;
    repeat (2) @(negedge clk_i);
    clr_i = 1'b0;
    @(negedge clk_i);
  endtask

  // Reference model: the entered digits as a queue, display = last four, zero padded.
  int q[$];
  int mode;  // 0 idle, 1 entry, 2 run, 3 pause

  function automatic int model_digits();
    int v = 0;
    foreach (q[i]) v = (v << 4) | q[i];
    return v & 16'hFFFF;
  endfunction

  task automatic model_key(input int code, output int e_err, output int e_ld);
    int sum;
    e_err = 0;
    e_ld  = 0;
    if (code <= 9) begin
      if (mode == 0) begin
        q = {code};
        mode = 1;
      end else if (mode == 1) begin
        if (q.size() >= 4 || q[q.size()-1] > 5) e_err = 1;
        else q.push_back(code);
      end else e_err = 1;
    end else if (code == 10) begin
      if (mode == 1 || mode == 3) begin
        q.delete();
        mode = 0;
      end else if (mode == 2) mode = 3;
    end else if (code == 11) begin
      if (mode == 0) begin
`ifdef TIMER_QUICK_START_EN
        q = {QuickSec / 10, QuickSec % 10};
        mode = 2;
        e_ld = 1;
`else
        e_err = 1;
`endif
      end else if (mode == 1) begin
        sum = 0;
        foreach (q[i]) sum += q[i];
        if (sum == 0) e_err = 1;
        else begin
          mode = 2;
          e_ld = 1;
        end
      end else if (mode == 2) e_err = 1;
      else mode = 2;
    end
  endtask

  typedef struct {
    logic [3:0]  code;
    logic [15:0] dig;
    logic        err;
    logic        run;
    logic        ld;
  } vec_t;

  function automatic vec_t mk(logic [3:0] c, logic [15:0] d, logic e, logic r, logic l);
    vec_t v;
    v.code = c; v.dig = d; v.err = e; v.run = r; v.ld = l;
    return v;
  endfunction

  vec_t tbl[$];

  initial begin
    int e0, l0, e_err, e_ld, code;
    tbl = {mk(4'h1, 16'h0001, 0, 0, 0), mk(4'h3, 16'h0013, 0, 0, 0), mk(4'h0, 16'h0130, 0, 0, 0),
           mk(4'hB, 16'h0130, 0, 1, 1), mk(4'hA, 16'h0130, 0, 0, 0), mk(4'hB, 16'h0130, 0, 1, 0),
           mk(4'hA, 16'h0130, 0, 0, 0), mk(4'hA, 16'h0000, 0, 0, 0), mk(4'h9, 16'h0009, 0, 0, 0),
           mk(4'h0, 16'h0009, 1, 0, 0), mk(4'hC, 16'h0009, 0, 0, 0), mk(4'hA, 16'h0000, 0, 0, 0),
           mk(4'h1, 16'h0001, 0, 0, 0), mk(4'h2, 16'h0012, 0, 0, 0), mk(4'h3, 16'h0123, 0, 0, 0),
           mk(4'h4, 16'h1234, 0, 0, 0), mk(4'h5, 16'h1234, 1, 0, 0), mk(4'hA, 16'h0000, 0, 0, 0),
           mk(4'h0, 16'h0000, 0, 0, 0), mk(4'hB, 16'h0000, 1, 0, 0), mk(4'hF, 16'h0000, 0, 0, 0),
           mk(4'hA, 16'h0000, 0, 0, 0), mk(4'h5, 16'h0005, 0, 0, 0), mk(4'hB, 16'h0005, 0, 1, 1),
           mk(4'h7, 16'h0005, 1, 1, 0), mk(4'hB, 16'h0005, 1, 1, 0)};

    clr_i = 1'b1; key_valid_i = 1'b0; key_code_i = 4'h0; timer_zero_i = 1'b0;
    do_reset();
    chk("reset_digits", digits(), 0);
    chk("reset_loadn", loadn_o, 1);
    chk("reset_run", run_o, 0);
    chk("reset_err", key_err_o, 0);

    // Start pressed in idle.
    e0 = err_cnt; l0 = load_cnt;
    press(4'hB, 2);
`ifdef TIMER_QUICK_START_EN
    chk("quick_digits", digits(), 16'h0030);
    chk("quick_err", err_cnt - e0, 0);
    chk("quick_load", load_cnt - l0, 1);
    chk("quick_run", run_o, 1);
    press(4'hA, 2);
    press(4'hA, 2);
`else
    chk("idle_start_err", err_cnt - e0, 1);
    chk("idle_start_run", run_o, 0);
    chk("idle_start_load", load_cnt - l0, 0);
`endif
    chk("idle_start_back_digits", digits(), 0);

    // One long hold must act once only.
    e0 = err_cnt;
    press(4'h4, 100);
    chk("hold_digits", digits(), 16'h0004);
    chk("hold_err", err_cnt - e0, 0);
    press(4'hA, 2);

    foreach (tbl[i]) begin
      e0 = err_cnt; l0 = load_cnt;
      press(tbl[i].code, 2);
      chk($sformatf("vec%0d_digits", i), digits(), tbl[i].dig);
      chk($sformatf("vec%0d_err", i), err_cnt - e0, tbl[i].err);
      chk($sformatf("vec%0d_run", i), run_o, tbl[i].run);
      chk($sformatf("vec%0d_load", i), load_cnt - l0, tbl[i].ld);
    end

    // Now running 00:05: key edge lands in the same cycle as timer_zero.
    e0 = err_cnt;
    @(negedge clk_i);
    key_code_i = 4'h5; key_valid_i = 1'b1;
    @(negedge clk_i);
    @(negedge clk_i);
    timer_zero_i = 1'b1;
    @(negedge clk_i);
    timer_zero_i = 1'b0;
    key_valid_i  = 1'b0;
    repeat (4) @(negedge clk_i);
    chk("tz_key_digits", digits(), 0);
    chk("tz_key_run", run_o, 0);
    chk("tz_key_err", err_cnt - e0, 0);
    press(4'h8, 2);
    chk("tz_then_idle_digit", digits(), 16'h0008);

    // Reset mid-cook takes effect immediately.
    press(4'hB, 2);
    chk("pre_clr_run", run_o, 1);
    @(negedge clk_i);
    #2 clr_i = 1'b1;
    #1;
    chk("clr_run", run_o, 0);
    chk("clr_loadn", loadn_o, 1);
    chk("clr_digits", digits(), 0);
    @(negedge clk_i);
    clr_i = 1'b0;
    @(negedge clk_i);

    // Random traffic against the model.
    q.delete(); mode = 0;
    for (int n = 0; n < 400; n++) begin
      e0 = err_cnt; l0 = load_cnt;
      if (mode == 2 && $urandom_range(0, 5) == 0) begin
        @(negedge clk_i);
        timer_zero_i = 1'b1;
        @(negedge clk_i);
        timer_zero_i = 1'b0;
        repeat (3) @(negedge clk_i);
        q.delete(); mode = 0; e_err = 0; e_ld = 0;
      end else begin
        code = $urandom_range(0, 99);
        if (code < 45) code = $urandom_range(0, 9);
        else if (code < 65) code = 10;
        else if (code < 88) code = 11;
        else code = $urandom_range(12, 15);
        press(4'(code), $urandom_range(1, 6));
        model_key(code, e_err, e_ld);
      end
      chk($sformatf("rnd%0d_digits", n), digits(), model_digits());
      chk($sformatf("rnd%0d_run", n), run_o, (mode == 2) ? 1 : 0);
      chk($sformatf("rnd%0d_err", n), err_cnt - e0, e_err);
      chk($sformatf("rnd%0d_load", n), load_cnt - l0, e_ld);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
